// File: rtl/exu_mdu.sv
// exu_mdu: RV32M multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Optional build macro MDU_FAST_MUL_EN: MUL* ops finish in one cycle on a full-width multiplier.
module exu_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_sys,
    input  logic            rst_sys,
    input  logic            i_pip_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_rd_addr,
    output logic            o_stall,
    output logic            o_valid,
    output logic            o_rd_wen,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_result
);
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q, acc_nxt;
    logic [XLEN-1:0]   opnd_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              neg_q, rneg_q;

    logic              accept, short_op, load_res;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, short_res, result_d;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

`ifdef MDU_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN-1:0] fast_prod;
    assign fast_a    = {a_signed & i_rs1[XLEN-1], i_rs1};
    assign fast_b    = {b_signed & i_rs2[XLEN-1], i_rs2};
    assign fast_prod = (2*XLEN)'(fast_a) * (2*XLEN)'(fast_b);
`endif

    // Operand magnitudes and the short-path (special case / fast multiply) result.
    always_comb begin
        a_signed  = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
        b_signed  = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
        a_neg     = a_signed & i_rs1[XLEN-1];
        b_neg     = b_signed & i_rs2[XLEN-1];
        a_mag     = a_neg ? -i_rs1 : i_rs1;
        b_mag     = b_neg ? -i_rs2 : i_rs2;
        div_zero  = i_op[2] && (i_rs2 == '0);
        div_ovf   = ((i_op == OP_DIV) || (i_op == OP_REM)) &&
                    (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
        short_op  = div_zero || div_ovf;
        short_res = '0;
        if (div_zero)
            short_res = i_op[1] ? i_rs1 : '1;
        else if (div_ovf)
            short_res = i_op[1] ? '0 : i_rs1;
`ifdef MDU_FAST_MUL_EN
        if (!i_op[2]) begin
            short_op  = 1'b1;
            short_res = (i_op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // acc_q holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (div_trial[XLEN])
                acc_nxt = {acc_q[2*XLEN-2:0], 1'b0};
            else
                acc_nxt = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod = neg_q ? -acc_nxt : acc_nxt;
        quo  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem  = rneg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       result_d = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result_d = quo;
            default:                      result_d = rem;
        endcase
    end

    // Valid/ready: a request transfers on the edge where i_valid & o_ready are both high;
    // the requester holds i_valid and its operands until then. o_valid is a single-cycle pulse.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        load_res = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid && o_ready) begin
                    accept   = 1'b1;
                    load_res = short_op;
                    state_d  = short_op ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (i_pip_flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    load_res = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_ready  = (state_q == ST_IDLE) && !i_pip_flush;
    assign o_stall  = (state_q == ST_CALC) || ((state_q == ST_IDLE) && i_valid);
    assign o_rd_wen = o_valid && (o_rd_addr != '0);

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            o_valid   <= 1'b0;
            o_rd_addr <= '0;
            o_result  <= '0;
        end else begin
            state_q <= state_d;
            o_valid <= (state_q == ST_DONE) && !i_pip_flush;
            if (accept) begin
                op_q   <= i_op;
                rd_q   <= i_rd_addr;
                cnt_q  <= CNT_W'(XLEN - 1);
                neg_q  <= a_neg ^ b_neg;
                rneg_q <= a_neg;
                opnd_q <= i_op[2] ? b_mag : a_mag;
                acc_q  <= {{XLEN{1'b0}}, (i_op[2] ? a_mag : b_mag)};
            end else if (state_q == ST_CALC) begin
                acc_q <= acc_nxt;
                if (cnt_q != '0)
                    cnt_q <= cnt_q - 1'b1;
            end
            // Result and destination are captured on entry to DONE.
            if (load_res) begin
                o_result  <= (state_q == ST_IDLE) ? short_res : result_d;
                o_rd_addr <= (state_q == ST_IDLE) ? i_rd_addr : rd_q;
            end
        end
    end
endmodule
